// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one external data-memory port (one read channel,
// one write channel) among NUM_CORES core data accessors. One transaction is
// in flight at a time. Cores are granted in round-robin order, and a read
// beats a write from the same core.
// Optional build macro ARB_FIXED_PRIORITY_EN: removes the round-robin pointer
// so the scan always starts at core 0 (lowest index wins).
module data_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int READ_NUM  = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CORES-1:0]                    core_read_valid,
  input  logic [NUM_CORES*ADDR_BITS-1:0]          core_read_address,
  output logic [NUM_CORES-1:0]                    core_read_ready,
  output logic [NUM_CORES*READ_NUM*DATA_BITS-1:0] core_read_data,
  input  logic [NUM_CORES-1:0]                    core_write_valid,
  input  logic [NUM_CORES*ADDR_BITS-1:0]          core_write_address,
  input  logic [NUM_CORES*DATA_BITS-1:0]          core_write_data,
  output logic [NUM_CORES-1:0]                    core_write_ready,
  output logic                                    mem_read_valid,
  output logic [ADDR_BITS-1:0]                    mem_read_address,
  input  logic                                    mem_read_ready,
  input  logic [READ_NUM*DATA_BITS-1:0]           mem_read_data,
  output logic                                    mem_write_valid,
  output logic [ADDR_BITS-1:0]                    mem_write_address,
  output logic [DATA_BITS-1:0]                    mem_write_data,
  input  logic                                    mem_write_ready
);

  localparam int GNT_BITS  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int LINE_BITS = READ_NUM * DATA_BITS;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELAY      = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic [GNT_BITS-1:0]              gnt_q, gnt_d;
  logic                             is_read_q, is_read_d;
  logic                             mem_read_valid_q, mem_read_valid_d;
  logic                             mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0]             mem_read_address_q, mem_read_address_d;
  logic [ADDR_BITS-1:0]             mem_write_address_q, mem_write_address_d;
  logic [DATA_BITS-1:0]             mem_write_data_q, mem_write_data_d;
  logic [NUM_CORES-1:0]             core_read_ready_q, core_read_ready_d;
  logic [NUM_CORES-1:0]             core_write_ready_q, core_write_ready_d;
  logic [NUM_CORES*LINE_BITS-1:0]   core_read_data_q, core_read_data_d;
`ifndef ARB_FIXED_PRIORITY_EN
  logic [GNT_BITS-1:0]              rr_ptr_q, rr_ptr_d;
`endif

  // Result of the request scan
  logic                 req_found;
  logic [GNT_BITS-1:0]  req_idx;
  logic                 req_is_read;
  logic [ADDR_BITS-1:0] req_addr;
  logic [DATA_BITS-1:0] req_wdata;
  logic                 gnt_valid;
  int                   scan_start;
  int                   scan_idx;

  // Find the first requesting core starting at the scan origin, wrapping around
  always_comb begin
    req_found   = 1'b0;
    req_idx     = '0;
    req_is_read = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    scan_idx    = 0;
`ifdef ARB_FIXED_PRIORITY_EN
    scan_start  = 0;
`else
    scan_start  = int'(rr_ptr_q);
`endif
    for (int k = 0; k < NUM_CORES; k++) begin
      scan_idx = scan_start + k;
      if (scan_idx >= NUM_CORES) scan_idx = scan_idx - NUM_CORES;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!req_found && (i == scan_idx) && (core_read_valid[i] || core_write_valid[i])) begin
          req_found   = 1'b1;
          req_idx     = GNT_BITS'(i);
          req_is_read = core_read_valid[i];
          req_addr    = core_read_valid[i] ? core_read_address[i*ADDR_BITS +: ADDR_BITS]
                                           : core_write_address[i*ADDR_BITS +: ADDR_BITS];
          req_wdata   = core_write_data[i*DATA_BITS +: DATA_BITS];
        end
      end
    end
  end

  // Current level of the granted core's valid for the transaction kind in flight
  always_comb begin
    gnt_valid = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (gnt_q == GNT_BITS'(i)) begin
        gnt_valid = is_read_q ? core_read_valid[i] : core_write_valid[i];
      end
    end
  end

  // Next-state and registered-output logic of the arbitration FSM
  always_comb begin
    state_d             = state_q;
    gnt_d               = gnt_q;
    is_read_d           = is_read_q;
    mem_read_valid_d    = mem_read_valid_q;
    mem_write_valid_d   = mem_write_valid_q;
    mem_read_address_d  = mem_read_address_q;
    mem_write_address_d = mem_write_address_q;
    mem_write_data_d    = mem_write_data_q;
    core_read_ready_d   = core_read_ready_q;
    core_write_ready_d  = core_write_ready_q;
    core_read_data_d    = core_read_data_q;
`ifndef ARB_FIXED_PRIORITY_EN
    rr_ptr_d            = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_found) begin
          gnt_d     = req_idx;
          is_read_d = req_is_read;
          if (req_is_read) begin
            mem_read_valid_d   = 1'b1;
            mem_read_address_d = req_addr;
            state_d            = READ_WAIT;
          end else begin
            mem_write_valid_d   = 1'b1;
            mem_write_address_d = req_addr;
            mem_write_data_d    = req_wdata;
            state_d             = WRITE_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          mem_read_valid_d = 1'b0;
          for (int i = 0; i < NUM_CORES; i++) begin
            if (gnt_q == GNT_BITS'(i)) begin
              core_read_data_d[i*LINE_BITS +: LINE_BITS] = mem_read_data;
              core_read_ready_d[i] = 1'b1;
            end
          end
          state_d = RELAY;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          mem_write_valid_d = 1'b0;
          for (int i = 0; i < NUM_CORES; i++) begin
            if (gnt_q == GNT_BITS'(i)) core_write_ready_d[i] = 1'b1;
          end
          state_d = RELAY;
        end
      end
      RELAY: begin
        if (!gnt_valid) begin
          core_read_ready_d  = '0;
          core_write_ready_d = '0;
`ifndef ARB_FIXED_PRIORITY_EN
          rr_ptr_d = (gnt_q == GNT_BITS'(NUM_CORES - 1)) ? '0 : gnt_q + 1'b1;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared by the asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q             <= IDLE;
      gnt_q               <= '0;
      is_read_q           <= 1'b0;
      mem_read_valid_q    <= 1'b0;
      mem_write_valid_q   <= 1'b0;
      mem_read_address_q  <= '0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
      core_read_ready_q   <= '0;
      core_write_ready_q  <= '0;
      core_read_data_q    <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_ptr_q            <= '0;
`endif
    end else begin
      state_q             <= state_d;
      gnt_q               <= gnt_d;
      is_read_q           <= is_read_d;
      mem_read_valid_q    <= mem_read_valid_d;
      mem_write_valid_q   <= mem_write_valid_d;
      mem_read_address_q  <= mem_read_address_d;
      mem_write_address_q <= mem_write_address_d;
      mem_write_data_q    <= mem_write_data_d;
      core_read_ready_q   <= core_read_ready_d;
      core_write_ready_q  <= core_write_ready_d;
      core_read_data_q    <= core_read_data_d;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_ptr_q            <= rr_ptr_d;
`endif
    end
  end

  assign mem_read_valid    = mem_read_valid_q;
  assign mem_read_address  = mem_read_address_q;
  assign mem_write_valid   = mem_write_valid_q;
  assign mem_write_address = mem_write_address_q;
  assign mem_write_data    = mem_write_data_q;
  assign core_read_ready   = core_read_ready_q;
  assign core_write_ready  = core_write_ready_q;
  assign core_read_data    = core_read_data_q;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares one external data-memory port (one read channel, one write channel) among NUM_CORES core-level data-memory interfaces.
- Each core interface is the output of that core's data accessor: wide read (READ_NUM words per beat), single-word write.
- Sits between the per-core data ports and the top-level data memory.
- Serves one transaction at a time; grants by round-robin.

Parameters:
- NUM_CORES, 4, number of requesting cores (any value >= 1, need not be a power of two)
- ADDR_BITS, 8, data-memory address width
- DATA_BITS, 8, data word width
- READ_NUM, 4, words returned per read beat

Ports:
- clk  in  1  clock; all logic rising-edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- core_read_valid  in  NUM_CORES  per-core read request
- core_read_address  in  NUM_CORES*ADDR_BITS  per-core read address, core i at slice [i*ADDR_BITS +: ADDR_BITS]
- core_read_ready  out  NUM_CORES  per-core read completion
- core_read_data  out  NUM_CORES*READ_NUM*DATA_BITS  per-core read data
- core_write_valid  in  NUM_CORES  per-core write request
- core_write_address  in  NUM_CORES*ADDR_BITS  per-core write address
- core_write_data  in  NUM_CORES*DATA_BITS  per-core write data
- core_write_ready  out  NUM_CORES  per-core write completion
- mem_read_valid  out  1  memory read request
- mem_read_address  out  ADDR_BITS  memory read address
- mem_read_ready  in  1  memory read done; mem_read_data valid this cycle
- mem_read_data  in  READ_NUM*DATA_BITS  memory read data
- mem_write_valid  out  1  memory write request
- mem_write_address  out  ADDR_BITS  memory write address
- mem_write_data  out  DATA_BITS  memory write data
- mem_write_ready  in  1  memory write done

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr_ptr=0.
  - Every output driven to 0: all valids, readys, addresses and data.
  - Reset mid-transaction abandons the transaction; a mem_*_ready arriving after release while in IDLE is ignored.
- FSM states: IDLE, READ_WAIT, WRITE_WAIT, RELAY.
- IDLE:
  - Scan cores rr_ptr, rr_ptr+1, ... wrapping modulo NUM_CORES. First core with read_valid or write_valid wins.
  - Within one core, read beats write when both are valid.
  - On grant, latch core index (gnt), address, and write data.
  - Read grant: next cycle mem_read_valid=1, state READ_WAIT.
  - Write grant: next cycle mem_write_valid=1, state WRITE_WAIT.
  - No requests: stay in IDLE.
- READ_WAIT / WRITE_WAIT:
  - Hold mem_*_valid and the latched address/data until mem_*_ready=1.
  - On that edge: drop mem_*_valid, latch mem_read_data (read only) into core_read_data slice gnt, assert core_*_ready[gnt], go to RELAY.
  - Ready arriving the same cycle valid first rises is legal (single-cycle memory).
- RELAY:
  - Hold core_*_ready[gnt] and the read data until the granted core's corresponding valid is low.
  - Then clear ready, set rr_ptr = (gnt==NUM_CORES-1) ? 0 : gnt+1, return to IDLE.
  - If the core already dropped valid, RELAY lasts exactly one cycle.
- Read data slices of non-granted cores hold their previous value.
- Requests are latched at grant: address/data changes after grant are ignored.
- A core dropping valid before its ready is a protocol violation; the transaction still completes and ready pulses for one cycle.
- Minimum latency, request seen in IDLE at cycle t:
  - mem valid at t+1.
  - core ready at t+2 with zero-wait memory.
  - back to IDLE at t+3.
- At most one mem_*_valid and at most one core_*_ready bit are high at any time.
- Starvation-free: a continuously asserted request is granted within NUM_CORES transactions.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined: rr_ptr is removed and the scan always starts at core 0 (lowest index wins); everything else is identical.
- Undefined: round-robin as above.

Test Plan:
- Single core 2 reads 0x10; memory ready after 3 cycles returning 0x04030201 -> mem_read_address=0x10; core_read_ready[2] high with core_read_data slice 2 = 0x04030201; other ready bits stay 0.
- All 4 cores read simultaneously and hold valid until ready, zero-wait memory -> grants in order 0,1,2,3, then rr_ptr=0; next simultaneous burst again starts at 0. With ARB_FIXED_PRIORITY_EN and core 0 re-requesting each time, core 0 is always granted first.
- Core 1 asserts read 0x20 and write 0x30/0xAB together -> read at 0x20 served first; write served in a later transaction after cores 2,3,0 get a turn if they are requesting; mem_write_data=0xAB.
- Core 3 granted, then rr_ptr wraps -> after the core 3 transaction rr_ptr=0 and core 0 beats a simultaneous core 1 request.
- reset=0 pulsed while in READ_WAIT, then mem_read_ready=1 after release -> all outputs 0 immediately, the late ready is ignored, no core_read_ready asserted.
- Core drops valid in the same cycle ready rises -> ready high exactly one cycle, FSM back in IDLE the next cycle.
